// File: rtl/apb_pkg.sv
// Shared types and address-map constants for the APB master bridge.
// The slave-select field sits at addr[SLV_MSB:SLV_LSB], just below the 16-bit base window.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic [15:0] APB_BASE_HI = 16'h1000;
  localparam int          SLV_MSB     = 15;
  localparam int          SLV_LSB     = 12;
  localparam int          TIMEOUT_DEF = 16;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decode: base-window match plus slave index range check.
// Only addr[31:12] matters for decode, so only that part is brought in.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [15:0] BASE_HI    = APB_BASE_HI
) (
  input  logic [31:SLV_LSB]      i_addr_hi,
  output logic                   o_hit,
  output logic [3:0]             o_idx,
  output logic [NUM_SLAVES-1:0]  o_sel
);

  logic [15:0] w_base;
  logic [3:0]  w_field;

  assign w_base  = i_addr_hi[31:16];
  assign w_field = i_addr_hi[SLV_MSB:SLV_LSB];
  assign o_hit   = (w_base == BASE_HI) && (32'(w_field) < 32'(NUM_SLAVES));
  assign o_idx   = w_field;

  always_comb begin
    o_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      o_sel[k] = o_hit && (w_field == 4'(k));
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-beat CPU request to APB transfer bridge with decode, wait-state handling and timeout.
// Handshake: req/we/addr/wdata are sampled only in IDLE; ready is a one-cycle pulse qualifying rdata/err.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter int          TIMEOUT    = TIMEOUT_DEF,
  parameter logic [15:0] BASE_HI    = APB_BASE_HI
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       req,
  input  logic                       we,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  output logic                       ready,
  output logic                       err,
  output logic [31:0]                PADDR,
  output logic [31:0]                PWDATA,
  output logic                       PWRITE,
  output logic                       PENABLE,
  output logic [NUM_SLAVES-1:0]      PSEL,
  input  logic [NUM_SLAVES*32-1:0]   PRDATA_i,
  input  logic [NUM_SLAVES-1:0]      PREADY_i,
  output apb_state_t                 dbg_state
);

  localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  apb_state_t              r_state, w_state_nxt;
  logic [31:0]             r_paddr, w_paddr_nxt;
  logic [31:0]             r_pwdata, w_pwdata_nxt;
  logic                    r_pwrite, w_pwrite_nxt;
  logic                    r_penable, w_penable_nxt;
  logic [NUM_SLAVES-1:0]   r_psel, w_psel_nxt;
  logic [31:0]             r_rdata, w_rdata_nxt;
  logic                    r_ready, w_ready_nxt;
  logic                    r_err, w_err_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]              r_idx, w_idx_nxt;

  logic                    w_dec_hit;
  logic [3:0]              w_dec_idx;
  logic [NUM_SLAVES-1:0]   w_dec_sel;
  logic [31:0]             w_prdata_sel;
  logic                    w_pready_sel;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_HI    (BASE_HI)
  ) u_dec (
    .i_addr_hi (addr[31:SLV_LSB]),
    .o_hit     (w_dec_hit),
    .o_idx     (w_dec_idx),
    .o_sel     (w_dec_sel)
  );

  // Only the latched slave's ready/data are looked at; other slaves are ignored.
  always_comb begin
    w_prdata_sel = '0;
    w_pready_sel = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (r_idx == 4'(k)) begin
        w_prdata_sel = PRDATA_i[k*32 +: 32];
        w_pready_sel = PREADY_i[k];
      end
    end
  end

  assign w_cnt_inc = r_cnt + CW'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_paddr_nxt   = r_paddr;
    w_pwdata_nxt  = r_pwdata;
    w_pwrite_nxt  = r_pwrite;
    w_penable_nxt = r_penable;
    w_psel_nxt    = r_psel;
    w_rdata_nxt   = r_rdata;
    w_ready_nxt   = 1'b0;
    w_err_nxt     = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    case (r_state)
      IDLE: begin
        if (req) begin
          if (w_dec_hit) begin
            w_paddr_nxt   = addr;
            w_pwrite_nxt  = we;
            w_pwdata_nxt  = we ? wdata : 32'h0;
            w_psel_nxt    = w_dec_sel;
            w_penable_nxt = 1'b0;
            w_idx_nxt     = w_dec_idx;
            w_cnt_nxt     = '0;
            w_state_nxt   = SETUP;
          end else begin
            w_ready_nxt = 1'b1;
            w_err_nxt   = 1'b1;
            w_rdata_nxt = 32'h0;
          end
        end
      end
      SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (w_pready_sel) begin
          w_rdata_nxt   = r_pwrite ? 32'h0 : w_prdata_sel;
          w_ready_nxt   = 1'b1;
          w_psel_nxt    = '0;
          w_penable_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_state_nxt   = IDLE;
        end else if (w_cnt_inc == CNT_LAST) begin
          // TIMEOUT-1 ACCESS cycles without PREADY: give up on the slave.
          w_rdata_nxt   = 32'h0;
          w_ready_nxt   = 1'b1;
          w_err_nxt     = 1'b1;
          w_psel_nxt    = '0;
          w_penable_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_state_nxt   = IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_psel_nxt    = '0;
        w_penable_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state   <= IDLE;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_penable <= 1'b0;
      r_psel    <= '0;
      r_rdata   <= '0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_idx     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_penable <= w_penable_nxt;
      r_psel    <= w_psel_nxt;
      r_rdata   <= w_rdata_nxt;
      r_ready   <= w_ready_nxt;
      r_err     <= w_err_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
    end
  end

  assign rdata     = r_rdata;
  assign ready     = r_ready;
  assign err       = r_err;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PWRITE    = r_pwrite;
  assign PENABLE   = r_penable;
  assign PSEL      = r_psel;
  assign dbg_state = r_state;

endmodule
